// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the MEM-stage data-memory sequencer.
package lc3b_types;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WMASK_W = 2;

  typedef logic [WORD_W-1:0]  lc3b_word;
  typedef logic [WMASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/resp port: master is the MEM-stage sequencer, slave is the memory.
interface mem_access_ctrl_if;
  import lc3b_types::*;

  logic          dmem_read;
  logic          dmem_write;
  lc3b_word      dmem_address;
  lc3b_word      dmem_wdata;
  lc3b_mem_wmask dmem_byte_enable;
  logic          dmem_resp;
  lc3b_word      dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );

endinterface

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for LDB/STB: write enables, store-data replication, load extraction.
module byte_lane_unit
  import lc3b_types::*;
(
  input  logic          byte_op_i,
  input  logic          addr_lsb_i,
  input  lc3b_word      mdr_i,
  input  lc3b_word      rdata_i,
  output lc3b_mem_wmask be_c_o,
  output lc3b_word      wdata_c_o,
  output lc3b_word      rdata_c_o
);

  // addr_lsb_i=1 addresses the high byte of the aligned word
  assign be_c_o    = byte_op_i ? (addr_lsb_i ? 2'b10 : 2'b01) : 2'b11;
  assign wdata_c_o = byte_op_i ? {mdr_i[7:0], mdr_i[7:0]} : mdr_i;
  assign rdata_c_o = byte_op_i ? {8'h00, (addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0])}
                               : rdata_i;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: single/indirect accesses, byte lanes, pipeline stall.
// MEM_ACCESS_PERF_EN builds the access and stall-cycle performance counters.
module mem_access_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic                indirect,
  input  logic                byte_op,
  input  lc3b_word            mar_in,
  input  lc3b_word            mdr_in,
  input  logic                advance,
  mem_access_ctrl_if.master   dmem,
  output logic                mem_stall,
  output lc3b_word            load_data,
  output logic [CNT_W-1:0]    perf_accesses,
  output logic [CNT_W-1:0]    perf_stall_cycles
);

  mem_state_t    state_q, state_d;
  logic [14:0]   ptr_q, ptr_d;
  lc3b_word      data_q, data_d;
  logic          gap_q, gap_d;

  logic          live, first_rd, byte_acc;
  lc3b_word      a1_addr, a1_wdata;
  lc3b_mem_wmask a1_be;
  lc3b_mem_wmask lane_be;
  lc3b_word      lane_wdata, lane_rdata;

  logic          rd_c, wr_c, stall_c, fin_c, fin_rd_c;
  lc3b_word      addr_c, wdata_c;
  lc3b_mem_wmask be_c;

  byte_lane_unit u_lanes (
    .byte_op_i  (byte_acc),
    .addr_lsb_i (mar_in[0]),
    .mdr_i      (mdr_in),
    .rdata_i    (dmem.dmem_rdata),
    .be_c_o     (lane_be),
    .wdata_c_o  (lane_wdata),
    .rdata_c_o  (lane_rdata)
  );

  // First access: pointer fetch for LDI/STI, otherwise the op itself
  assign live     = op_valid & (mem_rd | mem_wr);
  assign first_rd = mem_rd | indirect;
  assign byte_acc = byte_op & ~indirect;
  assign a1_addr  = (byte_acc & ~first_rd) ? mar_in : {mar_in[15:1], 1'b0};
  assign a1_be    = first_rd ? 2'b11 : lane_be;
  assign a1_wdata = first_rd ? '0 : lane_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
    end
  end

  // Next state and the combinational request/stall outputs
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    gap_d    = 1'b0;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    be_c     = '0;
    stall_c  = 1'b0;
    fin_c    = 1'b0;
    fin_rd_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (live && !reset) begin
          rd_c    = first_rd;
          wr_c    = ~first_rd;
          addr_c  = a1_addr;
          wdata_c = a1_wdata;
          be_c    = a1_be;
          stall_c = 1'b1;
          state_d = ACC1;
        end
      end
      ACC1: begin
        rd_c    = first_rd;
        wr_c    = ~first_rd;
        addr_c  = a1_addr;
        wdata_c = a1_wdata;
        be_c    = a1_be;
        stall_c = 1'b1;
        if (dmem.dmem_resp) begin
          if (indirect) begin
            ptr_d   = dmem.dmem_rdata[15:1];
            gap_d   = 1'b1;
            state_d = ACC2;
          end else begin
            fin_c    = 1'b1;
            fin_rd_c = first_rd;
          end
        end
      end
      ACC2: begin
        stall_c = 1'b1;
        // gap_q marks the mandatory dead cycle between the two requests
        if (!gap_q) begin
          rd_c    = ~mem_wr;
          wr_c    = mem_wr;
          addr_c  = {ptr_q, 1'b0};
          wdata_c = mem_wr ? mdr_in : '0;
          be_c    = 2'b11;
          if (dmem.dmem_resp) begin
            fin_c    = 1'b1;
            fin_rd_c = ~mem_wr;
          end
        end
      end
      DONE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin_c) begin
      stall_c = 1'b0;
      state_d = advance ? IDLE : DONE;
      if (fin_rd_c) data_d = lane_rdata;
    end
  end

  assign dmem.dmem_read        = rd_c;
  assign dmem.dmem_write       = wr_c;
  assign dmem.dmem_address     = addr_c;
  assign dmem.dmem_wdata       = wdata_c;
  assign dmem.dmem_byte_enable = be_c;
  assign mem_stall             = stall_c;
  assign load_data             = fin_rd_c ? lane_rdata : data_q;

`ifdef MEM_ACCESS_PERF_EN
  logic [CNT_W-1:0] acc_cnt_q, stall_cnt_q;

  // Counts only responses that complete an outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (dmem.dmem_resp && (rd_c || wr_c)) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      if (stall_c) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign perf_accesses     = acc_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;
`else
  assign perf_accesses     = '0;
  assign perf_stall_cycles = '0;
`endif

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
    !(op_valid && mem_rd && mem_wr && !indirect));

endmodule
